// File: rtl/fmanorm_pipe.sv
// FMA normalization stage: leading-zero count and shift-limit in S1, left shift in S2.
// Two register stages with valid/ready, flush and synchronous reset; feeds the rounder.
module fmanorm_pipe #(
  parameter int NF = 52,
  parameter int NE = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [3*NF+5:0]   Sm,
  input  logic [NE+1:0]     Se,
  input  logic              Ss,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [3*NF+5:0]   Mm,
  output logic [NE+1:0]     Me,
  output logic              Ms,
  output logic              SZero,
  output logic              Subn,
  output logic              Tiny
);

  localparam int SW = 3*NF+6;
  localparam int EW = NE+2;
  localparam int KW = NE+3;
  localparam int LW = $clog2(SW+1);

  localparam logic [KW-1:0] LIM_OFS = KW'(NF+2);
  localparam logic [EW-1:0] EXP_OFS = EW'(NF+3);

  // Priority encoder: the highest set bit wins; all-zero input yields SW.
  function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
    logic [LW-1:0] n;
    n = LW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) n = LW'(SW-1-i);
    return n;
  endfunction

  // ---------------- handshake ----------------
  logic r1_vld, r2_vld;
  logic w_s2_adv, w_s1_adv, w_acc, w_s2_load;

  assign w_s2_adv  = ~r2_vld | OutReady;
  assign w_s1_adv  = ~r1_vld | w_s2_adv;
  assign InReady   = w_s1_adv;
  assign w_acc     = InValid & w_s1_adv & ~flush;
  assign w_s2_load = r1_vld & w_s2_adv & ~flush;

  // ---------------- stage 1 registers ----------------
  logic [SW-1:0] r1_sm;
  logic [EW-1:0] r1_se;
  logic          r1_ss;

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_vld <= 1'b0;
      r1_sm  <= '0;
      r1_se  <= '0;
      r1_ss  <= 1'b0;
    end else begin
      if (flush)         r1_vld <= 1'b0;
      else if (w_s1_adv) r1_vld <= InValid;
      if (w_acc) begin
        r1_sm <= Sm;
        r1_se <= Se;
        r1_ss <= Ss;
      end
    end
  end

  // ---------------- stage 1 logic: LZC, limit, shift amount ----------------
  logic [LW-1:0] w_lzc;
  logic [KW-1:0] w_lim;
  logic          w_tiny;
  logic          w_zero;
  logic [LW-1:0] w_sh;
  logic [EW-1:0] w_me;

  assign w_lzc  = lzc(r1_sm);
  assign w_lim  = {r1_se[EW-1], r1_se} + LIM_OFS;
  assign w_tiny = w_lim[KW-1];
  assign w_zero = ~|r1_sm;

  // When Lim <= L the limit fits in LW bits since L <= SW.
  always_comb begin
    w_sh = '0;
    if (!w_tiny) begin
      if ({{(KW-LW){1'b0}}, w_lzc} < w_lim) w_sh = w_lzc;
      else                                  w_sh = w_lim[LW-1:0];
    end
  end

  assign w_me = r1_se + EXP_OFS - {{(EW-LW){1'b0}}, w_sh};

  // ---------------- stage 2 registers ----------------
  logic [SW-1:0] r2_sm;
  logic [LW-1:0] r2_sh;
  logic [EW-1:0] r2_me;
  logic          r2_ms;
  logic          r2_zero;
  logic          r2_nz;
  logic          r2_tiny;

  always_ff @(posedge clk) begin
    if (reset) begin
      r2_vld  <= 1'b0;
      r2_sm   <= '0;
      r2_sh   <= '0;
      r2_me   <= '0;
      r2_ms   <= 1'b0;
      r2_zero <= 1'b0;
      r2_nz   <= 1'b0;
      r2_tiny <= 1'b0;
    end else begin
      if (flush)         r2_vld <= 1'b0;
      else if (w_s2_adv) r2_vld <= r1_vld;
      if (w_s2_load) begin
        r2_sm   <= r1_sm;
        r2_sh   <= w_zero ? '0 : w_sh;
        r2_me   <= w_zero ? '0 : w_me;
        r2_ms   <= r1_ss;
        r2_zero <= w_zero;
        r2_nz   <= ~w_zero;
        r2_tiny <= w_tiny & ~w_zero;
      end
    end
  end

  // ---------------- stage 2 logic: the shift ----------------
  // Outputs depend only on S2 registers, so they hold while stalled.
  logic [SW-1:0] w_mm;

  assign w_mm     = r2_sm << r2_sh;
  assign Mm       = w_mm;
  assign Me       = r2_me;
  assign Ms       = r2_ms;
  assign SZero    = r2_zero;
  assign Subn     = r2_nz & ~w_mm[SW-1];
  assign Tiny     = r2_tiny;
  assign OutValid = r2_vld;

endmodule
